// File: rtl/dmem_param.sv
// dmem_param: single-port-per-direction data memory with byte-enable writes,
// a registered read port and a power-on / reset clear sweep.
//
// After reset the memory is walked from word 0 to DEPTH-1, writing zero to
// each word (busy=1). Once the sweep finishes, reads and writes are served.
//
// Ports:
//   clk          rising-edge clock
//   resetN       synchronous active-low reset (restarts the clear sweep)
//   readEnable   read request
//   readAddress  read word address
//   readData     registered read data (latency 1, held when no read)
//   readValid    readData carries a fresh read result this cycle
//   writeEnable  write request
//   writeAddress write word address
//   writeData    write data
//   byteEnable   per-byte write mask, bit i covers writeData[8i+7:8i]
//   busy         clear sweep in progress
//   addrError    one-cycle pulse, aligned with readValid, for an
//                out-of-range read and/or write request
module dmem_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH      = 512
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    readEnable,
    input  logic [ADDR_WIDTH-1:0]   readAddress,
    output logic [DATA_WIDTH-1:0]   readData,
    output logic                    readValid,
    input  logic                    writeEnable,
    input  logic [ADDR_WIDTH-1:0]   writeAddress,
    input  logic [DATA_WIDTH-1:0]   writeData,
    input  logic [DATA_WIDTH/8-1:0] byteEnable,
    output logic                    busy,
    output logic                    addrError
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_WIDTH-1:0]  LAST_IDX  = IDX_WIDTH'(DEPTH - 1);
    // One extra bit so DEPTH == 2^ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [IDX_WIDTH-1:0]    clear_ptr;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    is_ready;
    logic                    read_in_range;
    logic                    write_in_range;
    logic                    write_ok;
    logic [IDX_WIDTH-1:0]    read_idx;
    logic [IDX_WIDTH-1:0]    write_idx;
    logic [DATA_WIDTH-1:0]   read_word;

    assign is_ready       = (state == READY);
    assign busy           = (state == CLEAR);
    assign read_in_range  = ({1'b0, readAddress}  < DEPTH_EXT);
    assign write_in_range = ({1'b0, writeAddress} < DEPTH_EXT);
    assign write_ok       = is_ready && writeEnable && write_in_range;
    assign read_idx       = readAddress[IDX_WIDTH-1:0];
    assign write_idx      = writeAddress[IDX_WIDTH-1:0];

    // State register and clear pointer. The pointer stops at the last word
    // so it never wraps before the hand-over to READY.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state     <= CLEAR;
            clear_ptr <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR && clear_ptr != LAST_IDX) begin
                clear_ptr <= clear_ptr + IDX_WIDTH'(1);
            end
        end
    end

    // Next-state logic: leave CLEAR on the edge that zeroes the last word.
    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (clear_ptr == LAST_IDX) state_next = READY;
            READY:   state_next = READY;
            default: state_next = CLEAR;
        endcase
    end

    // Write-first read word: a same-cycle write to the read address is
    // merged byte-by-byte over the stored contents.
    always_comb begin
        read_word = mem[read_idx];
        if (write_ok && writeAddress == readAddress) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (byteEnable[i]) begin
                    read_word[8*i +: 8] = writeData[8*i +: 8];
                end
            end
        end
    end

    // Memory array: the sweep owns the array while clearing, afterwards only
    // in-range writes touch it, one byte lane at a time.
    always_ff @(posedge clk) begin
        if (resetN) begin
            if (state == CLEAR) begin
                mem[clear_ptr] <= '0;
            end else if (write_ok) begin
                for (int i = 0; i < NUM_BYTES; i++) begin
                    if (byteEnable[i]) begin
                        mem[write_idx][8*i +: 8] <= writeData[8*i +: 8];
                    end
                end
            end
        end
    end

    // Registered read port and error pulse. Out-of-range reads still
    // complete (with zero data) so the requester always sees readValid.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            readData  <= '0;
            readValid <= 1'b0;
            addrError <= 1'b0;
        end else begin
            readValid <= is_ready && readEnable;
            addrError <= is_ready && ((readEnable && !read_in_range) ||
                                      (writeEnable && !write_in_range));
            if (is_ready && readEnable) begin
                readData <= read_in_range ? read_word : '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_param.sv
// tb_dmem_param: drives three dmem_param instances with the same stimulus:
//   dut0: defaults (32-bit, 9-bit address, 512 words)
//   dut1: 32-bit, 9-bit address, 300 words (exercises out-of-range accesses)
//   dut2: 64-bit, 4-bit address, 16 words
// A behavioural model per instance predicts every cycle's outputs; the
// predictions go into a queue that a separate monitor drains and compares.
module tb_dmem_param;

    logic        clk = 1'b0;
    logic        resetN;
    logic        re;
    logic [8:0]  ra;
    logic        we;
    logic [8:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [3:0]  c_ra;
    logic [3:0]  c_wa;
    logic [63:0] c_wd;
    logic [7:0]  c_be;

    logic [31:0] a_rdata, b_rdata;
    logic [63:0] c_rdata;
    logic        a_rvalid, b_rvalid, c_rvalid;
    logic        a_busy, b_busy, c_busy;
    logic        a_err, b_err, c_err;

    int vectors     = 0;
    int miscompares = 0;

    // Free-running clock, 10 time units per period.
    initial begin
        forever #5 clk = ~clk;
    end

    dmem_param u_dut0 (
        .clk(clk), .resetN(resetN),
        .readEnable(re), .readAddress(ra), .readData(a_rdata), .readValid(a_rvalid),
        .writeEnable(we), .writeAddress(wa), .writeData(wd), .byteEnable(be),
        .busy(a_busy), .addrError(a_err)
    );

    dmem_param #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .DEPTH(300)) u_dut1 (
        .clk(clk), .resetN(resetN),
        .readEnable(re), .readAddress(ra), .readData(b_rdata), .readValid(b_rvalid),
        .writeEnable(we), .writeAddress(wa), .writeData(wd), .byteEnable(be),
        .busy(b_busy), .addrError(b_err)
    );

    dmem_param #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .DEPTH(16)) u_dut2 (
        .clk(clk), .resetN(resetN),
        .readEnable(re), .readAddress(c_ra), .readData(c_rdata), .readValid(c_rvalid),
        .writeEnable(we), .writeAddress(c_wa), .writeData(c_wd), .byteEnable(c_be),
        .busy(c_busy), .addrError(c_err)
    );

    // Reference model state: word arrays, remaining sweep cycles and the
    // read data each instance should currently be holding.
    int          dep [3] = '{512, 300, 16};
    int          nby [3] = '{4, 4, 8};
    int          amod[3] = '{512, 512, 16};
    logic [63:0] mm  [3][512];
    int          sweep[3];
    logic [63:0] hold [3];

    typedef struct packed {
        logic [63:0] data;
        logic        valid;
        logic        err;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];

    // One clock of stimulus: drive all instances at the falling edge and push
    // each model's prediction for the outputs after the next rising edge.
    task automatic apply_stimulus(input bit rn, input bit r_en, input int r_ad,
                                  input bit w_en, input int w_ad,
                                  input logic [63:0] w_dat, input logic [7:0] w_be);
        exp_t e;
        int   rk, wk;
        bit   rbad, wbad;
        @(negedge clk);
        resetN = rn;
        re     = r_en;
        we     = w_en;
        ra     = 9'(r_ad);
        wa     = 9'(w_ad);
        wd     = w_dat[31:0];
        be     = w_be[3:0];
        c_ra   = 4'(r_ad);
        c_wa   = 4'(w_ad);
        c_wd   = w_dat;
        c_be   = w_be;
        for (int k = 0; k < 3; k++) begin
            e  = '0;
            rk = r_ad % amod[k];
            wk = w_ad % amod[k];
            if (!rn) begin
                sweep[k] = dep[k];
                for (int a = 0; a < 512; a++) mm[k][a] = '0;
                hold[k] = '0;
            end else if (sweep[k] > 0) begin
                sweep[k]--;
            end else begin
                rbad = (rk >= dep[k]);
                wbad = (wk >= dep[k]);
                if (w_en && !wbad) begin
                    for (int b = 0; b < nby[k]; b++) begin
                        if (w_be[b]) mm[k][wk][8*b +: 8] = w_dat[8*b +: 8];
                    end
                end
                e.valid = r_en;
                e.err   = (r_en && rbad) || (w_en && wbad);
                if (r_en) hold[k] = rbad ? 64'h0 : mm[k][rk];
            end
            e.data = hold[k];
            e.busy = (sweep[k] != 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic idle();
        apply_stimulus(1'b1, 1'b0, 0, 1'b0, 0, 64'h0, 8'h0);
    endtask

    // Direct comparison of a sampled output against a required value.
    task automatic check_output(input string name, input logic [63:0] act,
                                input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Release reset and count, per instance, the cycles busy stays high.
    task automatic count_busy();
        int cnt[3] = '{0, 0, 0};
        idle();
        for (int n = 0; n < 2000; n++) begin
            if (a_busy) cnt[0]++;
            if (b_busy) cnt[1]++;
            if (c_busy) cnt[2]++;
            if (!a_busy && !b_busy && !c_busy) break;
            idle();
        end
        check_output("busy_len_dut0", 64'(cnt[0]), 64'd512);
        check_output("busy_len_dut1", 64'(cnt[1]), 64'd300);
        check_output("busy_len_dut2", 64'(cnt[2]), 64'd16);
    endtask

    // Monitor: after every rising edge, pop the three predictions for this
    // cycle and compare every output of every instance.
    always @(posedge clk) begin
        exp_t        e;
        logic [63:0] ad;
        logic        av, ae, ab;
        #1;
        if (exp_q.size() >= 3) begin
            for (int k = 0; k < 3; k++) begin
                e = exp_q.pop_front();
                case (k)
                    0:       begin ad = {32'h0, a_rdata}; av = a_rvalid; ae = a_err; ab = a_busy; end
                    1:       begin ad = {32'h0, b_rdata}; av = b_rvalid; ae = b_err; ab = b_busy; end
                    default: begin ad = c_rdata;          av = c_rvalid; ae = c_err; ab = c_busy; end
                endcase
                vectors++;
                if (ad !== e.data || av !== e.valid || ae !== e.err || ab !== e.busy) begin
                    miscompares++;
                    $display("[TB] FAIL scoreboard dut%0d @%0t: got data=%h valid=%b err=%b busy=%b, required data=%h valid=%b err=%b busy=%b",
                             k, $time, ad, av, ae, ab, e.data, e.valid, e.err, e.busy);
                end
            end
        end
    end

    // Main sequence: reset with a mid-sweep restart, directed cases, then
    // randomized traffic with one more reset in the middle.
    initial begin
        int r_ad, w_ad;
        resetN = 1'b0; re = 1'b0; we = 1'b0; ra = '0; wa = '0; wd = '0; be = '0;
        c_ra = '0; c_wa = '0; c_wd = '0; c_be = '0;

        apply_stimulus(1'b0, 1'b0, 0, 1'b0, 0, 64'h0, 8'h0);
        apply_stimulus(1'b0, 1'b0, 0, 1'b0, 0, 64'h0, 8'h0);
        check_output("reset_busy", 64'(a_busy), 64'd1);
        check_output("reset_rdata", 64'(a_rdata), 64'd0);

        // Traffic during the sweep must be ignored.
        for (int i = 0; i < 100; i++) begin
            apply_stimulus(1'b1, 1'($urandom), int'($urandom_range(0, 511)), 1'($urandom),
                           int'($urandom_range(0, 511)), {$urandom, $urandom}, 8'($urandom));
        end
        apply_stimulus(1'b0, 1'b0, 0, 1'b0, 0, 64'h0, 8'h0);
        apply_stimulus(1'b0, 1'b0, 0, 1'b0, 0, 64'h0, 8'h0);
        count_busy();

        $display("[TB] directed cases");
        apply_stimulus(1'b1, 1'b1, 10, 1'b0, 0, 64'h0, 8'h0);
        idle();
        check_output("read10_zero", 64'(a_rdata), 64'd0);
        check_output("read10_valid", 64'(a_rvalid), 64'd1);

        apply_stimulus(1'b1, 1'b1, 400, 1'b0, 0, 64'h0, 8'h0);
        idle();
        check_output("oor_read_data", 64'(b_rdata), 64'd0);
        check_output("oor_read_valid", 64'(b_rvalid), 64'd1);
        check_output("oor_read_err", 64'(b_err), 64'd1);
        idle();
        check_output("oor_err_one_cycle", 64'(b_err), 64'd0);
        apply_stimulus(1'b1, 1'b0, 0, 1'b1, 300, 64'hDEADBEEF, 8'hFF);
        idle();
        check_output("oor_write_err", 64'(b_err), 64'd1);
        apply_stimulus(1'b1, 1'b1, 0, 1'b0, 0, 64'h0, 8'h0);
        idle();
        check_output("oor_write_no_wrap", 64'(b_rdata), 64'd0);

        apply_stimulus(1'b1, 1'b0, 0, 1'b1, 10, 64'd12345, 8'h0F);
        apply_stimulus(1'b1, 1'b0, 0, 1'b1, 11, 64'd6789, 8'h0F);
        apply_stimulus(1'b1, 1'b1, 10, 1'b0, 0, 64'h0, 8'h0);
        apply_stimulus(1'b1, 1'b1, 11, 1'b0, 0, 64'h0, 8'h0);
        check_output("read_addr10", 64'(a_rdata), 64'd12345);
        idle();
        check_output("read_addr11", 64'(a_rdata), 64'd6789);

        apply_stimulus(1'b1, 1'b0, 0, 1'b1, 5, 64'h11223344, 8'h0F);
        apply_stimulus(1'b1, 1'b1, 5, 1'b1, 5, 64'hAABBCCDD, 8'b0101);
        idle();
        check_output("write_first_merge", 64'(a_rdata), 64'h11BB33DD);

        apply_stimulus(1'b1, 1'b0, 0, 1'b1, 15, 64'h0123456789ABCDEF, 8'hFF);
        apply_stimulus(1'b1, 1'b1, 15, 1'b0, 0, 64'h0, 8'h0);
        apply_stimulus(1'b1, 1'b1, 0, 1'b0, 0, 64'h0, 8'h0);
        check_output("wide_read15", c_rdata, 64'h0123456789ABCDEF);
        idle();
        check_output("wide_read0", c_rdata, 64'h0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            if (i >= 1500 && i < 1503) begin
                apply_stimulus(1'b0, 1'b1, 3, 1'b1, 3, 64'h0, 8'hFF);
            end else begin
                r_ad = $urandom_range(0, 1) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 511));
                w_ad = $urandom_range(0, 1) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 511));
                apply_stimulus(1'b1, 1'($urandom), r_ad, 1'($urandom), w_ad,
                               {$urandom, $urandom}, 8'($urandom));
            end
        end
        idle();
        @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
